// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared constants for the multicycle MIPS-lite control unit.
//   Opcode/funct values, datapath select codes (ALU, ALU source, register
//   write source/address, next-PC), FSM state encodings and the instruction
//   class enumeration produced by mc_ctrl_decode.
package mc_ctrl_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  // ALU operation
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  // ALU B operand source
  localparam logic ALU_SRC_REG = 1'b0;
  localparam logic ALU_SRC_EXT = 1'b1;

  // GPR write data source
  localparam logic [2:0] REG_WRITE_SRC_ALU  = 3'd0;
  localparam logic [2:0] REG_WRITE_SRC_MEM  = 3'd1;
  localparam logic [2:0] REG_WRITE_SRC_ZERO = 3'd2;
  localparam logic [2:0] REG_WRITE_SRC_ONE  = 3'd3;
  localparam logic [2:0] REG_WRITE_SRC_PC   = 3'd4;
  localparam logic [2:0] REG_WRITE_SRC_SRA  = 3'd5;

  // GPR write address select
  localparam logic [1:0] REG_WRITE_ADDR_RD       = 2'd0;
  localparam logic [1:0] REG_WRITE_ADDR_RT       = 2'd1;
  localparam logic [1:0] REG_WRITE_ADDR_OVERFLOW = 2'd2;
  localparam logic [1:0] REG_WRITE_ADDR_NPC      = 2'd3;

  // Next-PC select
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_RS     = 2'd3;

  // FSM state encodings
  localparam logic [3:0] ST_INIT   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_EXEC   = 4'd3;
  localparam logic [3:0] ST_WB     = 4'd4;
  localparam logic [3:0] ST_MEM_RD = 4'd5;
  localparam logic [3:0] ST_MEM_WB = 4'd6;
  localparam logic [3:0] ST_MEM_WR = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_JUMP   = 4'd9;
  localparam logic [3:0] ST_HALT   = 4'd10;

  typedef enum logic [4:0] {
    CLS_NOP, CLS_ADDU, CLS_SUBU, CLS_ORI, CLS_LUI, CLS_SLT, CLS_ADDI, CLS_SRA,
    CLS_LW, CLS_LB, CLS_SW, CLS_SB, CLS_BEQ, CLS_BGTZ, CLS_J, CLS_JAL, CLS_JR
  } instr_cls_t;

  function automatic logic is_byte_op(input instr_cls_t cls);
    return (cls == CLS_LB) || (cls == CLS_SB);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/status bundle between mc_ctrl and the multicycle
//   datapath.
//   datapath -> control : opcode, funct, zero, overflow, positive, signed_less
//   control -> datapath : alu_ctl, ext_op, alu_src, reg_src, reg_dst,
//                         reg_write, mem_write, mem_op, npc_sel, pc_write,
//                         rgs_ins_write, halted
//   modport master: the control unit; modport slave: the datapath.
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       positive;
  logic       signed_less;

  logic [1:0] alu_ctl;
  logic       ext_op;
  logic       alu_src;
  logic [2:0] reg_src;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic       mem_write;
  logic       mem_op;
  logic [1:0] npc_sel;
  logic       pc_write;
  logic       rgs_ins_write;
  logic       halted;

  modport master (
    input  opcode, funct, zero, overflow, positive, signed_less,
    output alu_ctl, ext_op, alu_src, reg_src, reg_dst, reg_write, mem_write,
           mem_op, npc_sel, pc_write, rgs_ins_write, halted
  );

  modport slave (
    output opcode, funct, zero, overflow, positive, signed_less,
    input  alu_ctl, ext_op, alu_src, reg_src, reg_dst, reg_write, mem_write,
           mem_op, npc_sel, pc_write, rgs_ins_write, halted
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational instruction classifier.
//   opcode, funct : in  instruction fields from the instruction register
//   cls           : out instruction class
//   illegal       : out 1 when opcode/funct is not a supported instruction
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output instr_cls_t cls,
  output logic       illegal
);
  always_comb begin
    cls = CLS_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = CLS_ADDU;
          FN_SUBU: cls = CLS_SUBU;
          FN_SLT:  cls = CLS_SLT;
          FN_JR:   cls = CLS_JR;
          FN_SRA:  cls = CLS_SRA;
          default: cls = CLS_NOP;
        endcase
      end
      OP_ORI:  cls = CLS_ORI;
      OP_LUI:  cls = CLS_LUI;
      OP_ADDI: cls = CLS_ADDI;
      OP_LW:   cls = CLS_LW;
      OP_LB:   cls = CLS_LB;
      OP_SW:   cls = CLS_SW;
      OP_SB:   cls = CLS_SB;
      OP_BEQ:  cls = CLS_BEQ;
      OP_BGTZ: cls = CLS_BGTZ;
      OP_J:    cls = CLS_J;
      OP_JAL:  cls = CLS_JAL;
      default: cls = CLS_NOP;
    endcase
  end

  assign illegal = (cls == CLS_NOP);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-lite control unit (Moore FSM).
//   clk : in  rising-edge clock
//   rst : in  asynchronous active-low reset
//   bus : mc_ctrl_if.master, opcode/funct/flags in, datapath controls out
// Parameter MEM_WAIT (0..7): extra MEM_RD cycles before load writeback.
// Macro MC_CTRL_ILLEGAL_TRAP_EN: undecoded instructions enter a sticky HALT
//   (halted=1); otherwise they behave as a NOP and halted is tied 0.
import mc_ctrl_pkg::*;

module mc_ctrl #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);
  logic [3:0] state, state_nxt;
  instr_cls_t cls_d, cls_q;
  logic       illegal;
  logic       ovf_q;
  logic [2:0] wait_cnt;
  logic       in_instr;

  mc_ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (cls_d),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      cls_q    <= CLS_NOP;
      ovf_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_DECODE) cls_q <= cls_d;
      if (state == ST_EXEC) begin
        if (cls_q == CLS_ADDI) ovf_q <= bus.overflow;
        wait_cnt <= 3'(MEM_WAIT);
      end else if (state == ST_MEM_RD && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = ST_INIT;
    case (state)
      ST_INIT:  state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_DECODE;
      ST_DECODE: begin
        if (illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          state_nxt = ST_HALT;
`else
          state_nxt = ST_FETCH;
`endif
        end else begin
          case (cls_d)
            CLS_BEQ, CLS_BGTZ:      state_nxt = ST_BRANCH;
            CLS_J, CLS_JAL, CLS_JR: state_nxt = ST_JUMP;
            default:                state_nxt = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_LW, CLS_LB: state_nxt = ST_MEM_RD;
          CLS_SW, CLS_SB: state_nxt = ST_MEM_WR;
          default:        state_nxt = ST_WB;
        endcase
      end
      ST_MEM_RD: state_nxt = (wait_cnt == '0) ? ST_MEM_WB : ST_MEM_RD;
      ST_WB, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP: state_nxt = ST_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_HALT: state_nxt = ST_HALT;
`endif
      default: state_nxt = ST_INIT;
    endcase
  end

  // ALU/extend/byte selects are driven from cls_q across every post-decode
  // state so they stay constant until the instruction retires.
  assign in_instr = (state == ST_EXEC)   || (state == ST_WB)     ||
                    (state == ST_MEM_RD) || (state == ST_MEM_WB) ||
                    (state == ST_MEM_WR) || (state == ST_BRANCH) ||
                    (state == ST_JUMP);

  always_comb begin
    bus.alu_ctl       = ALU_ADD;
    bus.ext_op        = 1'b0;
    bus.alu_src       = ALU_SRC_REG;
    bus.reg_src       = REG_WRITE_SRC_ALU;
    bus.reg_dst       = REG_WRITE_ADDR_RD;
    bus.reg_write     = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_op        = 1'b0;
    bus.npc_sel       = NPC_PC4;
    bus.pc_write      = 1'b0;
    bus.rgs_ins_write = 1'b0;
    bus.halted        = 1'b0;

    if (in_instr) begin
      bus.mem_op = is_byte_op(cls_q);
      case (cls_q)
        CLS_SUBU, CLS_SLT, CLS_BEQ, CLS_BGTZ: bus.alu_ctl = ALU_SUB;
        CLS_ORI: begin
          bus.alu_ctl = ALU_OR;
          bus.alu_src = ALU_SRC_EXT;
        end
        CLS_LUI: begin
          bus.alu_ctl = ALU_LUI;
          bus.alu_src = ALU_SRC_EXT;
        end
        CLS_ADDI, CLS_LW, CLS_LB, CLS_SW, CLS_SB: begin
          bus.ext_op  = 1'b1;
          bus.alu_src = ALU_SRC_EXT;
        end
        default: ;
      endcase
    end

    case (state)
      ST_FETCH: begin
        bus.rgs_ins_write = 1'b1;
        bus.pc_write      = 1'b1;
        bus.npc_sel       = NPC_PC4;
      end
      ST_WB: begin
        bus.reg_write = 1'b1;
        case (cls_q)
          CLS_ORI, CLS_LUI: bus.reg_dst = REG_WRITE_ADDR_RT;
          CLS_SLT: bus.reg_src = bus.signed_less ? REG_WRITE_SRC_ONE
                                                 : REG_WRITE_SRC_ZERO;
          CLS_ADDI: begin
            bus.reg_dst = ovf_q ? REG_WRITE_ADDR_OVERFLOW : REG_WRITE_ADDR_RT;
            bus.reg_src = ovf_q ? REG_WRITE_SRC_ONE : REG_WRITE_SRC_ALU;
          end
          CLS_SRA: bus.reg_src = REG_WRITE_SRC_SRA;
          default: ;
        endcase
      end
      ST_MEM_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_src   = REG_WRITE_SRC_MEM;
        bus.reg_dst   = REG_WRITE_ADDR_RT;
      end
      ST_MEM_WR: bus.mem_write = 1'b1;
      ST_BRANCH: begin
        bus.npc_sel  = NPC_BRANCH;
        bus.pc_write = (cls_q == CLS_BEQ) ? bus.zero
                                          : (bus.positive & ~bus.zero);
      end
      ST_JUMP: begin
        bus.pc_write = 1'b1;
        case (cls_q)
          CLS_JR:  bus.npc_sel = NPC_RS;
          CLS_JAL: begin
            bus.npc_sel   = NPC_JUMP;
            bus.reg_write = 1'b1;
            bus.reg_dst   = REG_WRITE_ADDR_NPC;
            bus.reg_src   = REG_WRITE_SRC_PC;
          end
          default: bus.npc_sel = NPC_JUMP;
        endcase
      end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ST_HALT: bus.halted = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl (MEM_WAIT=2).
// Outputs are packed into one vector {alu_ctl, ext_op, alu_src, reg_src,
// reg_dst, reg_write, mem_write, mem_op, npc_sel, pc_write, rgs_ins_write,
// halted} and compared against hand-built expectations at each negedge.
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  mc_ctrl_if bus ();

  mc_ctrl #(.MEM_WAIT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [16:0] ctl;
  assign ctl = {bus.alu_ctl, bus.ext_op, bus.alu_src, bus.reg_src, bus.reg_dst,
                bus.reg_write, bus.mem_write, bus.mem_op, bus.npc_sel,
                bus.pc_write, bus.rgs_ins_write, bus.halted};

  function automatic logic [16:0] mk(
    input logic [1:0] alu, input logic ext, input logic asrc,
    input logic [2:0] rsrc, input logic [1:0] rdst, input logic rw,
    input logic mw, input logic mop, input logic [1:0] npc,
    input logic pcw, input logic irw, input logic h);
    return {alu, ext, asrc, rsrc, rdst, rw, mw, mop, npc, pcw, irw, h};
  endfunction

  localparam logic [16:0] ZERO  = 17'h0;
  localparam logic [16:0] FETCH = 17'b00_0_0_000_00_0_0_0_00_1_1_0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
    bus.opcode = op;
    bus.funct  = fn;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_instr(6'b0, 6'b0);
    bus.zero = 0; bus.overflow = 0; bus.positive = 0; bus.signed_less = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL reset got=%h exp=%h", ctl, ZERO); end
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL init got=%h exp=%h", ctl, ZERO); end
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL first_fetch got=%h exp=%h", ctl, FETCH); end
  endtask

  task automatic test_alu();
    // addu
    set_instr(6'b000000, 6'b100001);
    step();
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL addu_decode got=%h exp=%h", ctl, ZERO); end
    step();
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL addu_exec got=%h exp=%h", ctl, ZERO); end
    step();
    n_cmp++; if (ctl !== mk(0,0,0,0,0,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL addu_wb got=%h exp=%h", ctl, mk(0,0,0,0,0,1,0,0,0,0,0,0)); end
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL addu_fetch got=%h exp=%h", ctl, FETCH); end
    // addi with overflow sampled in EXEC only
    set_instr(6'b001000, 6'b000000);
    step(); step();
    n_cmp++; if (ctl !== mk(0,1,1,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL addi_exec got=%h exp=%h", ctl, mk(0,1,1,0,0,0,0,0,0,0,0,0)); end
    bus.overflow = 1'b1;
    step();
    bus.overflow = 1'b0;
    #1;
    n_cmp++; if (ctl !== mk(0,1,1,3,2,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL addi_ovf_wb got=%h exp=%h", ctl, mk(0,1,1,3,2,1,0,0,0,0,0,0)); end
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL addi_fetch got=%h exp=%h", ctl, FETCH); end
    // addi without overflow; overflow raised in WB must be ignored
    step(); step();
    bus.overflow = 1'b0;
    step();
    bus.overflow = 1'b1;
    #1;
    n_cmp++; if (ctl !== mk(0,1,1,0,1,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL addi_noovf_wb got=%h exp=%h", ctl, mk(0,1,1,0,1,1,0,0,0,0,0,0)); end
    bus.overflow = 1'b0;
    step();
    // slt
    set_instr(6'b000000, 6'b101010);
    step(); step();
    n_cmp++; if (ctl !== mk(1,0,0,0,0,0,0,0,0,0,0,0)) begin n_fail++; $display("FAIL slt_exec got=%h exp=%h", ctl, mk(1,0,0,0,0,0,0,0,0,0,0,0)); end
    step();
    bus.signed_less = 1'b1; #1;
    n_cmp++; if (ctl !== mk(1,0,0,3,0,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL slt_wb_one got=%h exp=%h", ctl, mk(1,0,0,3,0,1,0,0,0,0,0,0)); end
    bus.signed_less = 1'b0; #1;
    n_cmp++; if (ctl !== mk(1,0,0,2,0,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL slt_wb_zero got=%h exp=%h", ctl, mk(1,0,0,2,0,1,0,0,0,0,0,0)); end
    step();
    // ori -> WB dst RT, zero-extended immediate
    set_instr(6'b001101, 6'b000000);
    step(); step(); step();
    n_cmp++; if (ctl !== mk(2,0,1,0,1,1,0,0,0,0,0,0)) begin n_fail++; $display("FAIL ori_wb got=%h exp=%h", ctl, mk(2,0,1,0,1,1,0,0,0,0,0,0)); end
    step();
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000111, 6'b000111};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       exp_pcw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      set_instr(ops[i], 6'b000000);
      step();
      bus.zero = zs[i]; bus.positive = 1'b1;
      step();
      n_cmp++; if (ctl !== mk(1,0,0,0,0,0,0,0,1,exp_pcw[i],0,0)) begin n_fail++; $display("FAIL branch%0d got=%h exp=%h", i, ctl, mk(1,0,0,0,0,0,0,0,1,exp_pcw[i],0,0)); end
      bus.zero = 1'b0; bus.positive = 1'b0;
      step();
      n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL branch%0d_fetch got=%h exp=%h", i, ctl, FETCH); end
    end
  endtask

  task automatic test_memory();
    logic [16:0] e;
    // lw then lb: EXEC, MEM_RD x3, MEM_WB, FETCH
    for (int b = 0; b < 2; b++) begin
      set_instr((b == 0) ? 6'b100011 : 6'b100000, 6'b000000);
      step(); step();
      e = mk(0,1,1,0,0,0,0,b[0],0,0,0,0);
      n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL load%0d_exec got=%h exp=%h", b, ctl, e); end
      for (int k = 0; k < 3; k++) begin
        step();
        n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL load%0d_memrd%0d got=%h exp=%h", b, k, ctl, e); end
      end
      step();
      e = mk(0,1,1,1,1,1,0,b[0],0,0,0,0);
      n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL load%0d_wb got=%h exp=%h", b, ctl, e); end
      step();
      n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL load%0d_fetch got=%h exp=%h", b, ctl, FETCH); end
    end
    // sw then sb
    for (int b = 0; b < 2; b++) begin
      set_instr((b == 0) ? 6'b101011 : 6'b101000, 6'b000000);
      step(); step(); step();
      e = mk(0,1,1,0,0,0,1,b[0],0,0,0,0);
      n_cmp++; if (ctl !== e) begin n_fail++; $display("FAIL store%0d_memwr got=%h exp=%h", b, ctl, e); end
      step();
      n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL store%0d_fetch got=%h exp=%h", b, ctl, FETCH); end
    end
  endtask

  task automatic test_jump();
    set_instr(6'b000011, 6'b000000);
    step(); step();
    n_cmp++; if (ctl !== mk(0,0,0,4,3,1,0,0,2,1,0,0)) begin n_fail++; $display("FAIL jal got=%h exp=%h", ctl, mk(0,0,0,4,3,1,0,0,2,1,0,0)); end
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL jal_fetch got=%h exp=%h", ctl, FETCH); end
    set_instr(6'b000000, 6'b001000);
    step(); step();
    n_cmp++; if (ctl !== mk(0,0,0,0,0,0,0,0,3,1,0,0)) begin n_fail++; $display("FAIL jr got=%h exp=%h", ctl, mk(0,0,0,0,0,0,0,0,3,1,0,0)); end
    step();
    set_instr(6'b000010, 6'b000000);
    step(); step();
    n_cmp++; if (ctl !== mk(0,0,0,0,0,0,0,0,2,1,0,0)) begin n_fail++; $display("FAIL j got=%h exp=%h", ctl, mk(0,0,0,0,0,0,0,0,2,1,0,0)); end
    step();
  endtask

  task automatic test_mid_reset();
    set_instr(6'b000000, 6'b100001);
    step(); step();
    rst = 1'b0; #1;
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL midrst_async got=%h exp=%h", ctl, ZERO); end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL midrst_init got=%h exp=%h", ctl, ZERO); end
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL midrst_fetch got=%h exp=%h", ctl, FETCH); end
  endtask

  task automatic test_illegal();
    set_instr(6'b111111, 6'b000000);
    step();
    n_cmp++; if (ctl !== ZERO) begin n_fail++; $display("FAIL illegal_decode got=%h exp=%h", ctl, ZERO); end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (ctl !== 17'h1) begin n_fail++; $display("FAIL halt%0d got=%h exp=%h", i, ctl, 17'h1); end
    end
`else
    step();
    n_cmp++; if (ctl !== FETCH) begin n_fail++; $display("FAIL illegal_nop_fetch got=%h exp=%h", ctl, FETCH); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_memory();
    test_jump();
    test_mid_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
